// File: rtl/neat_gene_aligner.sv
// rtl/neat_gene_aligner.sv - innovation-aligns two sorted parent gene streams into tagged pairs.
// Optional genome statistics are built only when NEAT_ALIGN_STATS_EN is defined.
module neat_gene_aligner #(
  parameter int GENE_SZ    = 64,
  parameter int ATTR_SZ    = 8,
  parameter int INNOV_SZ   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BIAS_ID    = 0,
  parameter int CNT_SZ     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic [GENE_SZ-1:0] p1_gene,
  input  logic               p1_last,
  input  logic               p2_valid,
  output logic               p2_ready,
  input  logic [GENE_SZ-1:0] p2_gene,
  input  logic               p2_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GENE_SZ-1:0] gene1_out,
  output logic [GENE_SZ-1:0] gene2_out,
  output logic               bubble,
  output logic               bias,
  output logic [1:0]         gene_class,
  output logic               gene_side,
  output logic               out_last,
  output logic               stats_valid,
  output logic [CNT_SZ-1:0]  match_cnt,
  output logic [CNT_SZ-1:0]  disjoint_cnt,
  output logic [CNT_SZ-1:0]  excess_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = GENE_SZ + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0] S_MERGE = 2'd0, S_TAIL1 = 2'd1, S_TAIL2 = 2'd2;
  localparam logic [1:0] C_MATCH = 2'd0, C_DISJ = 2'd1, C_EXCESS = 2'd2;

  logic [EW-1:0] r_mem1 [FIFO_DEPTH];
  logic [EW-1:0] r_mem2 [FIFO_DEPTH];
  logic [PW-1:0] r_wptr1, r_rptr1, r_wptr2, r_rptr2;
  logic [CW-1:0] r_cnt1, r_cnt2;
  logic          r_up;
  logic [1:0]    r_state;

  logic               r_out_valid, r_bubble, r_bias, r_side, r_last;
  logic [GENE_SZ-1:0] r_g1, r_g2;
  logic [1:0]         r_cls;

  logic               w_push1, w_push2, w_pop1, w_pop2, w_ne1, w_ne2, w_free, w_fire;
  logic [EW-1:0]      w_head1, w_head2;
  logic [GENE_SZ-1:0] w_gene1, w_gene2, w_g1, w_g2;
  logic               w_last1, w_last2, w_b1, w_b2;
  logic [INNOV_SZ-1:0] w_innov1, w_innov2;
  logic [1:0]         w_nstate, w_cls;
  logic               w_bub, w_bias, w_side, w_olast;

  // ready stays low through reset and rises on the first clock afterwards
  assign p1_ready = r_up && (r_cnt1 != DEPTH_C);
  assign p2_ready = r_up && (r_cnt2 != DEPTH_C);
  assign w_push1  = p1_valid && p1_ready;
  assign w_push2  = p2_valid && p2_ready;
  assign w_ne1    = (r_cnt1 != '0);
  assign w_ne2    = (r_cnt2 != '0);
  assign w_free   = !r_out_valid || out_ready;

  assign w_head1  = r_mem1[r_rptr1];
  assign w_head2  = r_mem2[r_rptr2];
  assign w_gene1  = w_head1[GENE_SZ-1:0];
  assign w_gene2  = w_head2[GENE_SZ-1:0];
  assign w_last1  = w_head1[GENE_SZ];
  assign w_last2  = w_head2[GENE_SZ];
  assign w_innov1 = w_gene1[GENE_SZ-1 -: INNOV_SZ];
  assign w_innov2 = w_gene2[GENE_SZ-1 -: INNOV_SZ];
  assign w_b1     = (w_gene1[ATTR_SZ-1:0] == ATTR_SZ'(BIAS_ID));
  assign w_b2     = (w_gene2[ATTR_SZ-1:0] == ATTR_SZ'(BIAS_ID));

  always_ff @(posedge clk) begin
    if (w_push1) r_mem1[r_wptr1] <= {p1_last, p1_gene};
    if (w_push2) r_mem2[r_wptr2] <= {p2_last, p2_gene};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_up    <= 1'b0;
      r_wptr1 <= '0;
      r_rptr1 <= '0;
      r_cnt1  <= '0;
      r_wptr2 <= '0;
      r_rptr2 <= '0;
      r_cnt2  <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_push1) r_wptr1 <= r_wptr1 + 1'b1;
      if (w_pop1)  r_rptr1 <= r_rptr1 + 1'b1;
      if (w_push2) r_wptr2 <= r_wptr2 + 1'b1;
      if (w_pop2)  r_rptr2 <= r_rptr2 + 1'b1;
      r_cnt1 <= r_cnt1 + CW'(w_push1) - CW'(w_pop1);
      r_cnt2 <= r_cnt2 + CW'(w_push2) - CW'(w_pop2);
    end
  end

  always_comb begin
    w_fire   = 1'b0;
    w_pop1   = 1'b0;
    w_pop2   = 1'b0;
    w_nstate = r_state;
    w_g1     = '0;
    w_g2     = '0;
    w_bub    = 1'b0;
    w_bias   = 1'b0;
    w_cls    = C_MATCH;
    w_side   = 1'b0;
    w_olast  = 1'b0;
    case (r_state)
      S_MERGE: begin
        if (w_ne1 && w_ne2 && w_free) begin
          w_fire = 1'b1;
          if (w_innov1 == w_innov2) begin
            w_pop1 = 1'b1;
            w_pop2 = 1'b1;
            w_g1   = w_gene1;
            w_g2   = w_gene2;
            w_bias = w_b1;
            if (w_last1 && w_last2) w_olast  = 1'b1;
            else if (w_last2)       w_nstate = S_TAIL1;
            else if (w_last1)       w_nstate = S_TAIL2;
          end else if (w_innov1 < w_innov2) begin
            w_pop1 = 1'b1;
            w_g1   = w_gene1;
            w_bub  = 1'b1;
            w_cls  = C_DISJ;
            w_bias = w_b1;
            if (w_last1) w_nstate = S_TAIL2;
          end else begin
            w_pop2 = 1'b1;
            w_g2   = w_gene2;
            w_bub  = 1'b1;
            w_cls  = C_DISJ;
            w_side = 1'b1;
            w_bias = w_b2;
            if (w_last2) w_nstate = S_TAIL1;
          end
        end
      end
      S_TAIL1: begin
        if (w_ne1 && w_free) begin
          w_fire = 1'b1;
          w_pop1 = 1'b1;
          w_g1   = w_gene1;
          w_bub  = 1'b1;
          w_cls  = C_EXCESS;
          w_bias = w_b1;
          if (w_last1) begin
            w_olast  = 1'b1;
            w_nstate = S_MERGE;
          end
        end
      end
      S_TAIL2: begin
        if (w_ne2 && w_free) begin
          w_fire = 1'b1;
          w_pop2 = 1'b1;
          w_g2   = w_gene2;
          w_bub  = 1'b1;
          w_cls  = C_EXCESS;
          w_side = 1'b1;
          w_bias = w_b2;
          if (w_last2) begin
            w_olast  = 1'b1;
            w_nstate = S_MERGE;
          end
        end
      end
      default: w_nstate = S_MERGE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_MERGE;
      r_out_valid <= 1'b0;
      r_g1        <= '0;
      r_g2        <= '0;
      r_bubble    <= 1'b0;
      r_bias      <= 1'b0;
      r_cls       <= C_MATCH;
      r_side      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_g1        <= w_g1;
        r_g2        <= w_g2;
        r_bubble    <= w_bub;
        r_bias      <= w_bias;
        r_cls       <= w_cls;
        r_side      <= w_side;
        r_last      <= w_olast;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign gene1_out  = r_g1;
  assign gene2_out  = r_g2;
  assign bubble     = r_bubble;
  assign bias       = r_bias;
  assign gene_class = r_cls;
  assign gene_side  = r_side;
  assign out_last   = r_last;

`ifdef NEAT_ALIGN_STATS_EN
  logic              w_accept;
  logic              r_stats_valid;
  logic [CNT_SZ-1:0] r_match, r_disj, r_excess;

  assign w_accept = r_out_valid && out_ready;

  // clearing after the stats pulse still counts a pair accepted in that same cycle
  function automatic logic [CNT_SZ-1:0] bump(input logic [CNT_SZ-1:0] c, input logic hit,
                                             input logic clr);
    if (clr) return hit ? CNT_SZ'(1) : '0;
    if (hit && !(&c)) return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stats_valid <= 1'b0;
      r_match       <= '0;
      r_disj        <= '0;
      r_excess      <= '0;
    end else begin
      r_stats_valid <= w_accept && r_last;
      r_match       <= bump(r_match,  w_accept && (r_cls == C_MATCH),  r_stats_valid);
      r_disj        <= bump(r_disj,   w_accept && (r_cls == C_DISJ),   r_stats_valid);
      r_excess      <= bump(r_excess, w_accept && (r_cls == C_EXCESS), r_stats_valid);
    end
  end

  assign stats_valid  = r_stats_valid;
  assign match_cnt    = r_match;
  assign disjoint_cnt = r_disj;
  assign excess_cnt   = r_excess;
`else
  assign stats_valid  = 1'b0;
  assign match_cnt    = '0;
  assign disjoint_cnt = '0;
  assign excess_cnt   = '0;
`endif
endmodule

// File: tb/tb_neat_gene_aligner.sv
// tb/tb_neat_gene_aligner.sv - table-driven bench for neat_gene_aligner.
module tb_neat_gene_aligner;
  logic        clk = 1'b0;
  logic        rst;
  logic        p1_valid, p1_ready, p1_last, p2_valid, p2_ready, p2_last;
  logic [63:0] p1_gene, p2_gene, gene1_out, gene2_out;
  logic        out_valid, out_ready, bubble, bias, gene_side, out_last, stats_valid;
  logic [1:0]  gene_class;
  logic [15:0] match_cnt, disjoint_cnt, excess_cnt;

  neat_gene_aligner dut (
    .clk(clk), .rst(rst),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_gene(p1_gene), .p1_last(p1_last),
    .p2_valid(p2_valid), .p2_ready(p2_ready), .p2_gene(p2_gene), .p2_last(p2_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .gene1_out(gene1_out), .gene2_out(gene2_out),
    .bubble(bubble), .bias(bias), .gene_class(gene_class), .gene_side(gene_side),
    .out_last(out_last), .stats_valid(stats_valid),
    .match_cnt(match_cnt), .disjoint_cnt(disjoint_cnt), .excess_cnt(excess_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tid;
    bit h1; int i1; int s1; bit l1;
    bit h2; int i2; int s2; bit l2;
    logic [1:0] cls; bit side; bit bub; bit bias; bit last;
  } row_t;

  typedef struct packed {
    logic [63:0] g1;
    logic [63:0] g2;
    logic bub; logic bias; logic [1:0] cls; logic side; logic last;
  } pair_t;

  row_t        tab[$];
  logic [64:0] q1[$], q2[$];
  pair_t       got[$];
  int          acc_cyc[$];
  int          errors = 0, checks = 0, cyc = 0;
  int          stats_hits, stats_late, clear_bad, nz_seen, w1cnt, w2cnt;
  logic [15:0] st_m, st_d, st_e;
  bit          prev_last_acc = 0, prev_stats = 0;

  function automatic logic [63:0] mk(input int innov, input int src);
    logic [15:0] iv;
    logic [7:0]  sv;
    iv = innov[15:0];
    sv = src[7:0];
    return {iv, 24'hC0FFEE, iv, sv};
  endfunction

  function automatic row_t rw(input int tid, input bit h1, input int i1, input int s1,
                              input bit l1, input bit h2, input int i2, input int s2,
                              input bit l2, input logic [1:0] cls, input bit side,
                              input bit bias, input bit last);
    row_t r;
    r.tid = tid; r.h1 = h1; r.i1 = i1; r.s1 = s1; r.l1 = l1;
    r.h2 = h2; r.i2 = i2; r.s2 = s2; r.l2 = l2;
    r.cls = cls; r.side = side; r.bub = !(h1 && h2); r.bias = bias; r.last = last;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (stats_valid) begin
      stats_hits++;
      st_m = match_cnt; st_d = disjoint_cnt; st_e = excess_cnt;
      if (!prev_last_acc) stats_late++;
    end
    if (prev_stats && (match_cnt != 0 || disjoint_cnt != 0 || excess_cnt != 0)) clear_bad++;
    if (stats_valid || match_cnt != 0 || disjoint_cnt != 0 || excess_cnt != 0) nz_seen++;
    prev_stats    = stats_valid;
    prev_last_acc = out_valid && out_ready && out_last;
    if (out_valid && out_ready) begin
      got.push_back({gene1_out, gene2_out, bubble, bias, gene_class, gene_side, out_last});
      acc_cyc.push_back(cyc);
    end
    if (p1_valid && p1_ready) w1cnt++;
    if (p2_valid && p2_ready) w2cnt++;
  end

  // called at posedge+1; pushes both queues concurrently, honouring ready
  task automatic send_all();
    int i1 = 0, i2 = 0, g = 0;
    bit a1, a2;
    while ((i1 < q1.size() || i2 < q2.size()) && g < 300) begin
      p1_valid = (i1 < q1.size());
      p2_valid = (i2 < q2.size());
      if (p1_valid) {p1_last, p1_gene} = q1[i1];
      if (p2_valid) {p2_last, p2_gene} = q2[i2];
      @(negedge clk);
      a1 = p1_valid && p1_ready;
      a2 = p2_valid && p2_ready;
      @(posedge clk); #1;
      if (a1) i1++;
      if (a2) i2++;
      g++;
    end
    p1_valid = 0; p2_valid = 0; p1_last = 0; p2_last = 0;
    chk("send_timeout", 128'(g < 300), 128'(1));
  endtask

  task automatic wait_pairs(input int n);
    int g = 0;
    while (got.size() < n && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("pair_count", 128'(got.size()), 128'(n));
  endtask

  task automatic run_genome(input int tid);
    int n = 0, em = 0, ed = 0, ee = 0, j = 0;
    q1.delete(); q2.delete(); got.delete();
    stats_hits = 0; stats_late = 0; clear_bad = 0; nz_seen = 0;
    foreach (tab[k]) if (tab[k].tid == tid) begin
      n++;
      if (tab[k].h1) q1.push_back({tab[k].l1, mk(tab[k].i1, tab[k].s1)});
      if (tab[k].h2) q2.push_back({tab[k].l2, mk(tab[k].i2, tab[k].s2)});
      if (tab[k].cls == 2'd0) em++;
      if (tab[k].cls == 2'd1) ed++;
      if (tab[k].cls == 2'd2) ee++;
    end
    send_all();
    wait_pairs(n);
    repeat (4) @(posedge clk);
    #1;
    foreach (tab[k]) if (tab[k].tid == tid) begin
      if (j < got.size()) begin
        chk($sformatf("t%0d_p%0d_genes", tid, j), {got[j].g1, got[j].g2},
            {(tab[k].h1 ? mk(tab[k].i1, tab[k].s1) : 64'd0),
             (tab[k].h2 ? mk(tab[k].i2, tab[k].s2) : 64'd0)});
        chk($sformatf("t%0d_p%0d_tags", tid, j),
            128'({got[j].bub, got[j].bias, got[j].cls, got[j].side, got[j].last}),
            128'({tab[k].bub, tab[k].bias, tab[k].cls, tab[k].side, tab[k].last}));
      end
      j++;
    end
`ifdef NEAT_ALIGN_STATS_EN
    chk($sformatf("t%0d_stats_pulses", tid), 128'(stats_hits), 128'(1));
    chk($sformatf("t%0d_counts", tid), 128'({st_m, st_d, st_e}),
        128'({em[15:0], ed[15:0], ee[15:0]}));
    chk($sformatf("t%0d_stats_timing", tid), 128'(stats_late), 128'(0));
    chk($sformatf("t%0d_counts_cleared", tid), 128'(clear_bad), 128'(0));
`else
    chk($sformatf("t%0d_stats_off", tid), 128'(nz_seen), 128'(0));
`endif
  endtask

  initial begin
    // genome 0: plain matches
    tab.push_back(rw(0, 1, 1, 3, 0, 1, 1, 3, 0, 2'd0, 0, 0, 0));
    tab.push_back(rw(0, 1, 2, 3, 0, 1, 2, 3, 0, 2'd0, 0, 0, 0));
    tab.push_back(rw(0, 1, 3, 3, 1, 1, 3, 3, 1, 2'd0, 0, 0, 1));
    // genome 1: p1 {1,3,5,6} vs p2 {1,2,5}; p2's gene 2 is a bias gene
    tab.push_back(rw(1, 1, 1, 3, 0, 1, 1, 3, 0, 2'd0, 0, 0, 0));
    tab.push_back(rw(1, 0, 0, 0, 0, 1, 2, 0, 0, 2'd1, 1, 1, 0));
    tab.push_back(rw(1, 1, 3, 3, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0));
    tab.push_back(rw(1, 1, 5, 3, 0, 1, 5, 3, 1, 2'd0, 0, 0, 0));
    tab.push_back(rw(1, 1, 6, 3, 1, 0, 0, 0, 0, 2'd2, 0, 0, 1));
    // genomes 2,3: bias on a match follows p1's source id
    tab.push_back(rw(2, 1, 4, 0, 1, 1, 4, 9, 1, 2'd0, 0, 1, 1));
    tab.push_back(rw(3, 1, 5, 7, 1, 1, 5, 0, 1, 2'd0, 0, 0, 1));
    // genome 4: p1 {2} vs p2 {1,3,4} exercises the p2 tail
    tab.push_back(rw(4, 0, 0, 0, 0, 1, 1, 3, 0, 2'd1, 1, 0, 0));
    tab.push_back(rw(4, 1, 2, 3, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0));
    tab.push_back(rw(4, 0, 0, 0, 0, 1, 3, 3, 0, 2'd2, 1, 0, 0));
    tab.push_back(rw(4, 0, 0, 0, 0, 1, 4, 0, 1, 2'd2, 1, 1, 1));
    // genome 5: single match after a mid-genome reset
    tab.push_back(rw(5, 1, 1, 3, 1, 1, 1, 3, 1, 2'd0, 0, 0, 1));

    rst = 0; out_ready = 0;
    p1_valid = 0; p2_valid = 0; p1_last = 0; p2_last = 0; p1_gene = '0; p2_gene = '0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'({p1_ready, p2_ready}), 128'(0));
    chk("rst_outputs", 128'({gene1_out, gene2_out}), 128'(0));
    chk("rst_counts", 128'({stats_valid, match_cnt, disjoint_cnt, excess_cnt}), 128'(0));
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("ready_before_clock", 128'({p1_ready, p2_ready}), 128'(0));
    @(posedge clk); #1;
    chk("ready_after_clock", 128'({p1_ready, p2_ready}), 128'(2'b11));

    out_ready = 1;
    for (int t = 0; t < 5; t++) run_genome(t);

    // backpressure: 8 matched genes, output stalled for 10 cycles
    q1.delete(); q2.delete(); got.delete(); acc_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      q1.push_back({k == 7, mk(10 + k, 3)});
      q2.push_back({k == 7, mk(10 + k, 3)});
    end
    w1cnt = 0; w2cnt = 0; out_ready = 0;
    fork
      send_all();
      begin
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_hold_early", {gene1_out, gene2_out}, {mk(10, 3), mk(10, 3)});
        repeat (7) begin @(posedge clk); #1; end
        chk("bp_hold_late", 128'({out_valid, gene1_out}), 128'({1'b1, mk(10, 3)}));
        chk("bp_writes", 128'({w1cnt[7:0], w2cnt[7:0]}), 128'({8'd5, 8'd5}));
        chk("bp_ready_low", 128'({p1_ready, p2_ready}), 128'(0));
        chk("bp_no_accept", 128'(got.size()), 128'(0));
        out_ready = 1;
      end
    join
    wait_pairs(8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk($sformatf("bp_p%0d", k), 128'({got[k].g1[63:48], got[k].g2[63:48], got[k].last}),
          128'({16'(10 + k), 16'(10 + k), k == 7}));
    if (acc_cyc.size() == 8)
      chk("bp_throughput", 128'(acc_cyc[7] - acc_cyc[0]), 128'(7));
    repeat (4) @(posedge clk);
    #1;

    // reset in the middle of a four-pair genome
    q1.delete(); q2.delete(); got.delete();
    for (int k = 0; k < 4; k++) begin
      q1.push_back({k == 3, mk(20 + k, 3)});
      q2.push_back({k == 3, mk(20 + k, 3)});
    end
    out_ready = 0;
    send_all();
    out_ready = 1;
    wait_pairs(2);
    chk("mid_valid_before_rst", 128'(out_valid), 128'(1));
    #2 rst = 0;
    #1;
    chk("mid_valid_after_rst", 128'(out_valid), 128'(0));
    chk("mid_ready_after_rst", 128'({p1_ready, p2_ready}), 128'(0));
    chk("mid_counts_after_rst", 128'({match_cnt, disjoint_cnt, excess_cnt}), 128'(0));
    stats_hits = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_no_stats", 128'(stats_hits), 128'(0));
    chk("mid_pairs_seen", 128'(got.size()), 128'(2));
    run_genome(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neat_gene_aligner.md
# neat_gene_aligner

Parametrised successor to the PE front end: accepts two parent gene streams, each sorted by ascending innovation number, and emits innovation-aligned gene pairs to the crossover/mutation PE back end. Each pair is tagged with a bubble flag, a bias flag and a match/disjoint/excess class. Each parent has its own buffered valid/ready input, and the output is registered with valid/ready. Optional compatibility counters feed the speciation unit.

## Interface
- GENE_SZ, 64, gene width in bits.
- ATTR_SZ, 8, node-id field width; source node id = gene[ATTR_SZ-1:0].
- INNOV_SZ, 16, innovation field width; innovation = gene[GENE_SZ-1 -: INNOV_SZ].
- FIFO_DEPTH, 4, per-parent input FIFO depth; power of 2, ≥2.
- BIAS_ID, 0, source node id that marks a bias gene.
- CNT_SZ, 16, statistics counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- p1_valid / p2_valid  in  1  parent gene valid.
- p1_ready / p2_ready  out  1  parent FIFO not full.
- p1_gene / p2_gene  in  GENE_SZ  parent gene.
- p1_last / p2_last  in  1  final gene of this parent's genome.
- out_valid  out  1  aligned pair valid.
- out_ready  in  1  back end accepts pair.
- gene1_out / gene2_out  out  GENE_SZ  aligned genes; the absent side is 0.
- bubble  out  1  one side is absent.
- bias  out  1  source id of the present gene(s) == BIAS_ID.
- gene_class  out  2  0 = match, 1 = disjoint, 2 = excess.
- gene_side  out  1  side of the unmatched gene (0 = p1, 1 = p2); 0 on match.
- out_last  out  1  final pair of the genome pair.
- stats_valid  out  1  one-cycle pulse when statistics are final.
- match_cnt / disjoint_cnt / excess_cnt  out  CNT_SZ each  genome counts.

## Operation
- Input side: each parent writes its FIFO on valid&&ready, storing {last, gene}.
- FSM states:
  - MERGE: both heads are required.
  - TAIL1: p2 is exhausted; only p1 remains.
  - TAIL2: p1 is exhausted; only p2 remains.
- MERGE decisions (fire only when both FIFOs are non-empty and the output register is free):
  - innov1 == innov2: emit both genes, class = match, bubble = 0; pop both FIFOs.
  - innov1 < innov2: emit gene1 with gene2 = 0, class = disjoint, side = 0, bubble = 1; pop p1 only.
  - innov2 < innov1: the mirror case (side = 1); pop p2 only.
- MERGE transitions:
  - Popping p2's last gene while p1's last has not yet been popped → TAIL1.
  - Popping p1's last gene while p2's last has not yet been popped → TAIL2.
  - Popping both last genes in the same cycle → out_last = 1, stay in MERGE.
- TAIL1 / TAIL2: emit the present side's head as class = excess, bubble = 1, other side's gene = 0. Popping that side's last gene → out_last = 1, return to MERGE.
- bias is computed from whichever gene(s) are emitted. On a match, p1's source id is used.
- The output register holds all fields stable while out_valid && !out_ready.
- A new decision fires when the register is empty or is being accepted in the same cycle.
- Every genome pair is guaranteed to contain at least one gene per parent.

## Timing
- FIFO write at cycle t; head is visible at t+1; out_valid is registered at t+2 at the earliest.
- Sustained throughput is 1 pair/cycle while out_ready = 1 and the heads are available.
- p*_ready deasserts when the FIFO is full. A simultaneous pop and push when full is not accepted; ready is combinational from the registered count only.
- A FIFO read pointer wraps modulo FIFO_DEPTH.
- Outputs after reset (asynchronous, rst low):
  - All outputs are 0 and out_valid = 0.
  - FIFOs are empty, pointers are 0.
  - FSM is in MERGE, counters are 0.
  - p*_ready rises on the first clock after rst deasserts.
- Reset asserted mid-genome discards all buffered and in-flight genes. No partial stats_valid is produced.
- Counters increment when a pair is accepted (out_valid && out_ready), according to its class.
- Counters saturate at 2^CNT_SZ−1.
- stats_valid pulses in the cycle after an out_last pair is accepted, holding the final counts. All counters clear to 0 on the following cycle.

## Configuration
- NEAT_ALIGN_STATS_EN defined: the counters and the stats_valid logic are synthesised as described above.
- Not defined: match_cnt, disjoint_cnt, excess_cnt and stats_valid are tied to 0, and no counter flops are built. Alignment behaviour is unchanged.

## Test plan
- Match: both parents send innov {1,2,3}, with last on 3 → three match pairs, bubble = 0, out_last on the third. match_cnt = 3 at stats_valid.
- Disjoint/excess: p1 sends {1,3,5,6}, p2 sends {1,2,5} → pairs in order:
  - match 1;
  - disjoint p2 2;
  - disjoint p1 3;
  - match 5;
  - excess p1 6 with out_last.
  - Counts at stats_valid: 2 / 2 / 1.
- Bias: p1 gene with source id 0 paired with a p2 gene of equal innovation → bias = 1 with class = match. A source id of 7 → bias = 0.
- Backpressure: out_ready held 0 for 10 cycles with FIFO_DEPTH = 4 → p1_ready/p2_ready fall after 4 writes plus the output register, and outputs stay stable. Releasing out_ready → 1 pair/cycle with no loss or duplication.
- Reset mid-genome: rst pulled low after 2 of 4 pairs → out_valid = 0 immediately. The next genome {1} vs {1} yields a single match with out_last, and counts restart from 0.
- Macro off: rerun the disjoint/excess test → identical pairs, stats_valid and all counts remain 0.
